instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 178 +++++++++++++++++
 tb/tb_instr_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage feeding decode.
// Owns the fetch PC, reads a 1-cycle-latency synchronous instruction memory,
// and buffers returned words in a small skid FIFO so decode stalls never
// drop an instruction. Handles branch redirects (flush) and a sticky halt.
// Optional build macro INSTR_FETCH_PERF_EN adds stall_cnt / flush_cnt
// saturating performance counters.
module instr_fetch #(
   parameter int unsigned        PC_W       = 22,
   parameter int unsigned        INSTR_W    = 32,
   parameter logic [PC_W-1:0]    RESET_PC   = '0,
   parameter int unsigned        FIFO_DEPTH = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = 32'hC800_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_re,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    redirect_PC,
   input  logic               hlt,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    PC_out,
   output logic               instr_valid,
   output logic               halted
`ifdef INSTR_FETCH_PERF_EN
   ,output logic [31:0]       stall_cnt
   ,output logic [31:0]       flush_cnt
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CNT_W = 3;

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [PC_W-1:0]    r_fetch_pc;
   logic               r_inflight;
   logic [PC_W-1:0]    r_inflight_pc;
   logic               r_go;
   logic [PC_W-1:0]    r_last_pc;

   logic [INSTR_W-1:0] r_fifo_instr [FIFO_DEPTH];
   logic [PC_W-1:0]    r_fifo_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic               w_run;
   logic               w_accept_flush;
   logic               w_do_halt;
   logic               w_clear;
   logic [CNT_W-1:0]   w_occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_run          = (r_state == S_RUN);
   assign w_valid        = (r_count != '0);
   assign w_pop          = w_valid & ~stall;
   assign w_accept_flush = w_run & flush;
   assign w_do_halt      = w_run & hlt & ~flush;
   assign w_clear        = w_accept_flush | w_do_halt;
   assign w_push         = r_inflight & ~w_clear;
   // Occupancy seen by the issue check: buffered + in flight, minus what
   // leaves this cycle. count >= pop always, so no underflow.
   assign w_occ          = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_RUN;
      else        r_state <= w_state_nxt;
   end

   // Next state, issue decision and halted flag
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_RUN: begin
            w_issue = r_go & (w_occ < CNT_W'(FIFO_DEPTH));
            if (hlt && !flush) w_state_nxt = S_HALTED;
         end
         S_HALTED: halted = 1'b1;
      endcase
   end

   assign imem_re   = w_issue;
   assign imem_addr = w_issue ? r_fetch_pc : '0;

   // Fetch PC, in-flight tracking and the first-cycle-after-reset gate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_go          <= 1'b0;
      end else begin
         r_go <= 1'b1;
         if (w_accept_flush) begin
            r_fetch_pc <= redirect_PC;
            r_inflight <= 1'b0;
         end else if (w_do_halt) begin
            r_inflight <= 1'b0;
         end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
               r_fetch_pc    <= r_fetch_pc + 1'b1;
               r_inflight_pc <= r_fetch_pc;
            end
         end
      end
   end

   // Skid FIFO pointers and occupancy; flush/halt empty it at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // FIFO storage write of the returning word and its PC
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_rdata;
         r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      end
   end

   // Remember the PC last shown to decode so PC_out holds when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_last_pc <= '0;
      else if (w_valid) r_last_pc <= r_fifo_pc[r_rd_ptr];
   end

   assign instr_valid = w_valid;
   assign instr       = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
   assign PC_out      = w_valid ? r_fifo_pc[r_rd_ptr]    : r_last_pc;

`ifdef INSTR_FETCH_PERF_EN
   // Saturating stall / accepted-flush counters, frozen once halted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (w_run) begin
         if (w_valid && stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1))            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed table for reset release and
// stall, hand sequences for flush/halt/wrap, then randomized traffic against a
// queue-based reference model of the fetch stage.
module tb_instr_fetch;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] NOP   = 32'hC800_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_re;
   logic [21:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic [21:0] redirect_PC;
   logic        hlt;
   logic [31:0] instr;
   logic [21:0] PC_out;
   logic        instr_valid;
   logic        halted;
`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   instr_fetch #(.PC_W(22), .INSTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_re     (imem_re),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .flush       (flush),
      .redirect_PC (redirect_PC),
      .hlt         (hlt),
      .instr       (instr),
      .PC_out      (PC_out),
      .instr_valid (instr_valid),
      .halted      (halted)
`ifdef INSTR_FETCH_PERF_EN
      ,.stall_cnt  (stall_cnt)
      ,.flush_cnt  (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   bit scramble = 1'b0;

   function automatic logic [31:0] mem_word(input logic [21:0] a);
      if (scramble) return {a[9:0], a} ^ 32'h5A5A_0000;
      return {10'h0, a};
   endfunction

   // Synchronous memory, 1-cycle latency; junk when not read
   always @(posedge clk) imem_rdata <= imem_re ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [21:0] mq[$];
   bit          m_infl;
   logic [21:0] m_ipc, m_fpc, m_last;
   bit          m_halted, m_go;
   int unsigned m_scnt, m_fcnt;

   function automatic bit m_valid();
      return !m_halted && (mq.size() != 0);
   endfunction

   function automatic bit m_re(input bit s);
      int occ;
      occ = mq.size() + int'(m_infl) - int'(m_valid() && !s);
      return m_go && !m_halted && (occ < int'(DEPTH));
   endfunction

   task automatic m_reset();
      mq.delete();
      m_infl = 0; m_ipc = '0; m_fpc = '0; m_last = '0;
      m_halted = 0; m_go = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic drive_and_check(input bit s, input bit f, input bit h, input logic [21:0] r);
      logic [21:0] hd;
      @(negedge clk);
      stall = s; flush = f; hlt = h; redirect_PC = r;
      #1;
      hd = m_last;
      if (m_valid()) hd = mq[0];
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid()});
      chk("PC_out", {10'b0, PC_out}, {10'b0, hd});
      chk("instr", instr, m_valid() ? mem_word(hd) : NOP);
      chk("imem_re", {31'b0, imem_re}, {31'b0, m_re(s)});
      chk("imem_addr", {10'b0, imem_addr}, m_re(s) ? {10'b0, m_fpc} : 32'h0);
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("no_overflow", (dut.r_count <= 3'(DEPTH)) ? 32'd1 : 32'd0, 32'd1);
`ifdef INSTR_FETCH_PERF_EN
      chk("stall_cnt", stall_cnt, m_scnt);
      chk("flush_cnt", flush_cnt, m_fcnt);
`endif
   endtask

   task automatic edge_update(input bit s, input bit f, input bit h, input logic [21:0] r);
      bit v, re;
      v  = m_valid();
      re = m_re(s);
      @(posedge clk);
      if (!m_halted) begin
         if (v && s) m_scnt++;
         if (f)      m_fcnt++;
         if (v)      m_last = mq[0];
         if (f) begin
            mq.delete(); m_infl = 0; m_fpc = r;
         end else if (h) begin
            mq.delete(); m_infl = 0; m_halted = 1;
         end else begin
            if (v && !s) void'(mq.pop_front());
            if (m_infl)  mq.push_back(m_ipc);
            if (re) begin
               m_ipc = m_fpc;
               m_fpc = m_fpc + 22'd1;
            end
            m_infl = re;
         end
      end
      m_go = 1;
   endtask

   task automatic step(input bit s, input bit f, input bit h, input logic [21:0] r);
      drive_and_check(s, f, h, r);
      edge_update(s, f, h, r);
   endtask

   // Asynchronous reset asserted mid-cycle, released mid-high-phase
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", {10'b0, PC_out}, 32'd0);
      chk("rst_re", {31'b0, imem_re}, 32'd0);
      chk("rst_addr", {10'b0, imem_addr}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      m_reset();
      stall = 0; flush = 0; hlt = 0; redirect_PC = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      bit          stall;
      bit          exp_re;
      logic [21:0] exp_addr;
      bit          exp_valid;
      logic [21:0] exp_pc;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, hc;
      bit s, f, h;
      logic [21:0] r;

      // cycles after reset release, word = address, stall over PC 3
      tbl[0]  = '{0, 0, 22'd0, 0, 22'd0};
      tbl[1]  = '{0, 1, 22'd0, 0, 22'd0};
      tbl[2]  = '{0, 1, 22'd1, 0, 22'd0};
      tbl[3]  = '{0, 1, 22'd2, 1, 22'd0};
      tbl[4]  = '{0, 1, 22'd3, 1, 22'd1};
      tbl[5]  = '{0, 1, 22'd4, 1, 22'd2};
      tbl[6]  = '{1, 0, 22'd0, 1, 22'd3};
      tbl[7]  = '{1, 0, 22'd0, 1, 22'd3};
      tbl[8]  = '{1, 0, 22'd0, 1, 22'd3};
      tbl[9]  = '{1, 0, 22'd0, 1, 22'd3};
      tbl[10] = '{1, 0, 22'd0, 1, 22'd3};
      tbl[11] = '{0, 1, 22'd5, 1, 22'd3};
      tbl[12] = '{0, 1, 22'd6, 1, 22'd4};
      tbl[13] = '{0, 1, 22'd7, 1, 22'd5};
      tbl[14] = '{0, 1, 22'd8, 1, 22'd6};

      stall = 0; flush = 0; hlt = 0; redirect_PC = '0;
      rst_n = 1'b1;
      do_reset();

      for (int i = 0; i < 15; i++) begin
         drive_and_check(tbl[i].stall, 0, 0, '0);
         chk($sformatf("tbl%0d_re", i), {31'b0, imem_re}, {31'b0, tbl[i].exp_re});
         chk($sformatf("tbl%0d_addr", i), {10'b0, imem_addr}, {10'b0, tbl[i].exp_addr});
         chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
         chk($sformatf("tbl%0d_pc", i), {10'b0, PC_out}, {10'b0, tbl[i].exp_pc});
         chk($sformatf("tbl%0d_instr", i), instr, tbl[i].exp_valid ? {10'b0, tbl[i].exp_pc} : NOP);
         edge_update(tbl[i].stall, 0, 0, '0);
      end

      // Flush while PC 7 presented and PC 8 in flight
      drive_and_check(0, 1, 0, 22'h100);
      chk("flush_head_pc7", {10'b0, PC_out}, 32'd7);
      edge_update(0, 1, 0, 22'h100);
      drive_and_check(0, 0, 0, '0);
      chk("flush_next_re", {31'b0, imem_re}, 32'd1);
      chk("flush_next_addr", {10'b0, imem_addr}, 32'h100);
      chk("flush_next_valid", {31'b0, instr_valid}, 32'd0);
      edge_update(0, 0, 0, '0);
      step(0, 0, 0, '0);
      #1;
      chk("redir_valid", {31'b0, instr_valid}, 32'd1);
      chk("redir_pc", {10'b0, PC_out}, 32'h100);

      // Halt at PC 12, later flush ignored
      do_reset();
      k = 0;
      while (!(m_valid() && mq[0] == 22'd12) && k < 50) begin
         step(0, 0, 0, '0);
         k++;
      end
      chk("reach_pc12", (k < 50) ? 32'd1 : 32'd0, 32'd1);
      step(0, 0, 1, '0);
      #1;
      chk("halt_halted", {31'b0, halted}, 32'd1);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_instr", instr, NOP);
      repeat (3) step(1, 1, 0, 22'h55);
      step(0, 1, 1, 22'h66);
      #1;
      chk("halt_sticky", {31'b0, halted}, 32'd1);
      chk("halt_no_re", {31'b0, imem_re}, 32'd0);

      // hlt and flush together: flush wins
      do_reset();
      repeat (5) step(0, 0, 0, '0);
      step(0, 1, 1, 22'd40);
      #1;
      chk("hltflush_not_halted", {31'b0, halted}, 32'd0);
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      #1;
      chk("resume_valid", {31'b0, instr_valid}, 32'd1);
      chk("resume_pc40", {10'b0, PC_out}, 32'd40);

      // PC wrap plus perf counters: 3 stalled cycles and one flush
      do_reset();
      repeat (3) step(0, 0, 0, '0);
      repeat (3) step(1, 0, 0, '0);
      step(0, 1, 0, 22'h3FFFFF);
`ifdef INSTR_FETCH_PERF_EN
      #1;
      chk("perf_stall3", stall_cnt, 32'd3);
      chk("perf_flush1", flush_cnt, 32'd1);
`endif
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      #1;
      chk("wrap_top_valid", {31'b0, instr_valid}, 32'd1);
      chk("wrap_top_pc", {10'b0, PC_out}, 32'h3FFFFF);
      step(0, 0, 0, '0);
      #1;
      chk("wrap_zero_pc", {10'b0, PC_out}, 32'd0);
      chk("wrap_zero_instr", instr, 32'd0);

      // Randomized traffic against the model
      scramble = 1'b1;
      do_reset();
      hc = 0;
      for (int n = 0; n < 2000; n++) begin
         if (hc > 4 || $urandom_range(0, 299) == 0) begin
            do_reset();
            hc = 0;
         end
         s = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 19) == 0);
         h = ($urandom_range(0, 59) == 0);
         r = ($urandom_range(0, 3) == 0) ? 22'h3FFFFD : 22'($urandom);
         step(s, f, h, r);
         if (m_halted) hc++;
         else          hc = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
